ram_mp: RTL and testbench

- Parametrised successor of the core data RAM: one byte-masked write port, RD_PORTS registered read ports, out-of-range detection.
- Hardware clear sequencer zeroes the array one word per cycle. This replaces the old single-cycle reset clear, which does not synthesize for large depths.
- Sits between the LSU/IF stages and the bus; `busy_o` gates pipeline issue.

---
 rtl/buceros_pkg.sv | 25 ++
 rtl/ram_rd_port.sv | 69 ++++++
 rtl/ram_mp.sv | 121 ++++++++++++
 tb/tb_ram_mp.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buceros_pkg.sv
// Shared state encoding, constants and sizing helpers for the multi-port data RAM.
// Build option RAM_MP_RAW_BYPASS_EN makes same-index read/write collisions write-first.
package buceros_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int MAX_W = 1024;
    localparam logic [MAX_W-1:0] ZERO_WORD = '0;

    function automatic int lane_cnt(input int dw);
        return dw / 8;
    endfunction

    function automatic int lane_bits(input int dw);
        return $clog2(dw / 8);
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_rd_port.sv
// One registered read port: range check, valid/err/data registers, optional bypass.
// Build option RAM_MP_RAW_BYPASS_EN enables the write-first merge.
module ram_rd_port
    import buceros_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16384,
    parameter int ADDR_W = 32,
    parameter int IW     = idx_width(DEPTH),
    parameter int NB     = lane_cnt(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic [IW-1:0]     idx,
    input  logic [DATA_W-1:0] word,
`ifdef RAM_MP_RAW_BYPASS_EN
    input  logic              wr_act,
    input  logic [IW-1:0]     wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [NB-1:0]     wr_be,
`endif
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              err
);

    localparam int LB = lane_bits(DATA_W);

    logic [ADDR_W-1:0] word_addr;
    logic              ok;
    logic [DATA_W-1:0] rdata;

    assign word_addr = addr >> LB;
    assign ok        = word_addr < ADDR_W'(DEPTH);
    assign idx       = ok ? word_addr[IW-1:0] : '0;

`ifdef RAM_MP_RAW_BYPASS_EN
    always_comb begin
        rdata = word;
        if (wr_act && ok && (wr_idx == idx)) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be[k]) rdata[8*k +: 8] = wr_data[8*k +: 8];
            end
        end
    end
`else
    assign rdata = word;
`endif

    // Data holds its last value when no request is serviced.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            err   <= 1'b0;
            data  <= '0;
        end else if (ready && req) begin
            valid <= 1'b1;
            err   <= !ok;
            data  <= ok ? rdata : ZERO_WORD[DATA_W-1:0];
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_mp.sv
// Data RAM: byte-masked write port, RD_PORTS read ports, word-per-cycle clear FSM.
// Build option RAM_MP_RAW_BYPASS_EN makes same-index read/write collisions write-first.
module ram_mp
    import buceros_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16384,
    parameter int ADDR_W   = 32,
    parameter int RD_PORTS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_i,
    input  logic [RD_PORTS-1:0]        rd_req_i,
    input  logic [RD_PORTS*ADDR_W-1:0] rd_addr_i,
    output logic [RD_PORTS*DATA_W-1:0] rd_data_o,
    output logic [RD_PORTS-1:0]        rd_valid_o,
    output logic [RD_PORTS-1:0]        rd_err_o,
    input  logic                       wr_en_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic [DATA_W/8-1:0]        wr_be_i,
    output logic                       wr_err_o,
    output logic                       busy_o
);

    localparam int NB = lane_cnt(DATA_W);
    localparam int LB = lane_bits(DATA_W);
    localparam int IW = idx_width(DEPTH);

    state_t            state, state_nxt;
    logic [IW-1:0]     cnt;
    logic              cnt_last;
    logic              ready;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_word;
    logic              wr_ok;
    logic              wr_act;
    logic [IW-1:0]     wr_idx;

    logic [IW-1:0]     rd_idx  [RD_PORTS];
    logic [DATA_W-1:0] rd_word [RD_PORTS];

    assign wr_word  = wr_addr_i >> LB;
    assign wr_ok    = wr_word < ADDR_W'(DEPTH);
    assign wr_idx   = wr_ok ? wr_word[IW-1:0] : '0;
    assign wr_act   = ready && wr_en_i && wr_ok;
    assign cnt_last = cnt == IW'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) cnt <= cnt + IW'(1);
            else if (clr_i)        cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_CLEAR: if (cnt_last) state_nxt = ST_READY;
            ST_READY: if (clr_i)    state_nxt = ST_CLEAR;
            default:                state_nxt = ST_CLEAR;
        endcase
    end

    always_comb begin
        busy_o = state == ST_CLEAR;
        ready  = state == ST_READY;
    end

    // Clear owns the array while busy; user writes only land in READY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[cnt] <= ZERO_WORD[DATA_W-1:0];
            end else if (wr_act) begin
                for (int k = 0; k < NB; k++) begin
                    if (wr_be_i[k]) mem[wr_idx][8*k +: 8] <= wr_data_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) wr_err_o <= 1'b0;
        else     wr_err_o <= ready && wr_en_i && !wr_ok;
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        assign rd_word[p] = mem[rd_idx[p]];

        ram_rd_port #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .ready   (ready),
            .req     (rd_req_i[p]),
            .addr    (rd_addr_i[p*ADDR_W +: ADDR_W]),
            .idx     (rd_idx[p]),
            .word    (rd_word[p]),
`ifdef RAM_MP_RAW_BYPASS_EN
            .wr_act  (wr_act),
            .wr_idx  (wr_idx),
            .wr_data (wr_data_i),
            .wr_be   (wr_be_i),
`endif
            .data    (rd_data_o[p*DATA_W +: DATA_W]),
            .valid   (rd_valid_o[p]),
            .err     (rd_err_o[p])
        );
    end

endmodule

// File: tb/tb_ram_mp.sv
// Directed testbench for ram_mp with DEPTH=16, DATA_W=32, RD_PORTS=2.
// Expected RAW result follows RAM_MP_RAW_BYPASS_EN.
module tb_ram_mp;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 32;
    localparam int RD_PORTS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [1:0]  rd_req = '0;
    logic [63:0] rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_valid;
    logic [1:0]  rd_err;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        wr_err;
    logic        busy;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_mem [DEPTH];

    ram_mp #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .RD_PORTS (RD_PORTS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr),
        .rd_req_i   (rd_req),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .rd_err_o   (rd_err),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .wr_be_i    (wr_be),
        .wr_err_o   (wr_err),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic rd(input int p, input logic [31:0] a);
        rd_req = '0;
        rd_req[p] = 1'b1;
        rd_addr[p*32 +: 32] = a;
        tick();
        rd_req = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be = be;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        for (int i = 0; i < DEPTH; i++) dut.mem[i] = 32'hFFFF_FFFF;
        rst = 1'b1;
        tick();
        tick();
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 1", busy);
        end
        n_chk++;
        if (rd_valid !== 2'b00 || rd_err !== 2'b00 || wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got valid=%b err=%b werr=%b expected 00 00 0",
                     rd_valid, rd_err, wr_err);
        end
        n_chk++;
        if (rd_data !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0", rd_data);
        end
        rst = 1'b0;
        count_busy(n);
        n_chk++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL reset_clear_len: got %0d cycles expected 16", n);
        end
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            rd(0, 32'(4 * i));
            n_chk++;
            if (rd_valid[0] !== 1'b1 || rd_data[31:0] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_readback[%0d]: got v=%b d=%h expected v=1 d=00000000",
                         i, rd_valid[0], rd_data[31:0]);
            end
        end
    endtask

    task automatic test_byte_lane();
        wr(32'h08, 32'h1122_3344, 4'hF);
        wr(32'h08, 32'hAABB_CCDD, 4'h5);
        exp_mem[2] = 32'h11BB_33DD;
        rd(0, 32'h08);
        n_chk++;
        if (rd_valid[0] !== 1'b1 || rd_data[31:0] !== 32'h11BB_33DD) begin
            n_fail++;
            $display("FAIL byte_lane: got v=%b d=%h expected v=1 d=11bb33dd",
                     rd_valid[0], rd_data[31:0]);
        end
        tick();
        n_chk++;
        if (rd_valid[0] !== 1'b0 || rd_data[31:0] !== 32'h11BB_33DD) begin
            n_fail++;
            $display("FAIL idle_hold: got v=%b d=%h expected v=0 d=11bb33dd",
                     rd_valid[0], rd_data[31:0]);
        end
    endtask

    task automatic test_raw();
        logic [31:0] exp_raw;
`ifdef RAM_MP_RAW_BYPASS_EN
        exp_raw = 32'hCAFE_BABE;
`else
        exp_raw = 32'h0000_0000;
`endif
        wr_en = 1'b1;
        wr_addr = 32'h0C;
        wr_data = 32'hCAFE_BABE;
        wr_be = 4'hF;
        rd_req = 2'b01;
        rd_addr[31:0] = 32'h0C;
        tick();
        wr_en = 1'b0;
        rd_req = '0;
        exp_mem[3] = 32'hCAFE_BABE;
        n_chk++;
        if (rd_valid[0] !== 1'b1 || rd_data[31:0] !== exp_raw) begin
            n_fail++;
            $display("FAIL raw_same_edge: got v=%b d=%h expected v=1 d=%h",
                     rd_valid[0], rd_data[31:0], exp_raw);
        end
        rd(0, 32'h0C);
        n_chk++;
        if (rd_data[31:0] !== 32'hCAFE_BABE) begin
            n_fail++;
            $display("FAIL raw_after: got %h expected cafebabe", rd_data[31:0]);
        end
    endtask

    task automatic test_out_of_range();
        rd(1, 32'h08);
        n_chk++;
        if (rd_valid[1] !== 1'b1 || rd_err[1] !== 1'b0 || rd_data[63:32] !== 32'h11BB_33DD) begin
            n_fail++;
            $display("FAIL port1_read: got v=%b e=%b d=%h expected v=1 e=0 d=11bb33dd",
                     rd_valid[1], rd_err[1], rd_data[63:32]);
        end
        rd(1, 32'h40);
        n_chk++;
        if (rd_valid[1] !== 1'b1 || rd_err[1] !== 1'b1 || rd_data[63:32] !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_read: got v=%b e=%b d=%h expected v=1 e=1 d=00000000",
                     rd_valid[1], rd_err[1], rd_data[63:32]);
        end
        wr(32'h44, 32'hDEAD_BEEF, 4'hF);
        n_chk++;
        if (wr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_write_err: got %b expected 1", wr_err);
        end
        tick();
        n_chk++;
        if (wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_write_pulse: got %b expected 0", wr_err);
        end
        for (int i = 0; i < DEPTH; i++) begin
            rd(1, 32'(4 * i));
            n_chk++;
            if (rd_err[1] !== 1'b0 || rd_data[63:32] !== exp_mem[i]) begin
                n_fail++;
                $display("FAIL oor_untouched[%0d]: got e=%b d=%h expected e=0 d=%h",
                         i, rd_err[1], rd_data[63:32], exp_mem[i]);
            end
        end
    endtask

    task automatic test_dual_port();
        wr(32'h04, 32'h1234_5678, 4'hF);
        exp_mem[1] = 32'h1234_5678;
        rd_req = 2'b11;
        rd_addr = {32'h04, 32'h05};
        tick();
        rd_req = '0;
        n_chk++;
        if (rd_valid !== 2'b11 || rd_err !== 2'b00) begin
            n_fail++;
            $display("FAIL dual_flags: got v=%b e=%b expected v=11 e=00", rd_valid, rd_err);
        end
        n_chk++;
        if (rd_data !== {32'h1234_5678, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL dual_data: got %h expected 1234567812345678", rd_data);
        end
    endtask

    task automatic test_clear();
        int n;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_busy: got %b expected 1", busy);
        end
        rd_req = 2'b01;
        rd_addr[31:0] = 32'h08;
        tick();
        rd_req = '0;
        n_chk++;
        if (rd_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_read_ignored: got v=%b expected 0", rd_valid[0]);
        end
        count_busy(n);
        n_chk++;
        if (n + 1 !== 16) begin
            n_fail++;
            $display("FAIL clr_len: got %0d cycles expected 16", n + 1);
        end
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
        rd(0, 32'h08);
        n_chk++;
        if (rd_valid[0] !== 1'b1 || rd_data[31:0] !== 32'h0) begin
            n_fail++;
            $display("FAIL clr_zeroed: got v=%b d=%h expected v=1 d=00000000",
                     rd_valid[0], rd_data[31:0]);
        end
    endtask

    task automatic test_rst_mid_clear();
        int n;
        wr(32'h3C, 32'hA5A5_A5A5, 4'hF);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (7) tick();
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_clear_busy: got %b expected 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy(n);
        n_chk++;
        if (n !== 16) begin
            n_fail++;
            $display("FAIL rst_restart_len: got %0d cycles expected 16", n);
        end
        rd(1, 32'h3C);
        n_chk++;
        if (rd_valid[1] !== 1'b1 || rd_data[63:32] !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_restart_zero: got v=%b d=%h expected v=1 d=00000000",
                     rd_valid[1], rd_data[63:32]);
        end
    endtask

    initial begin
        test_reset();
        test_byte_lane();
        test_raw();
        test_out_of_range();
        test_dual_port();
        test_clear();
        test_rst_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
